// File: rtl/alu_types_pkg.sv
// Shared ALU types: operation encoding, arbiter FSM states and requester count.
package alu_types;

    typedef enum logic [2:0] {
        ADD,
        SUB,
        AND,
        OR,
        XOR,
        SLT,
        SLL,
        SRL
    } alu_control_t;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } alu_arb_state_t;

    localparam int ALU_ARB_NUM_REQ = 2;

endpackage

// File: rtl/alu.sv
// Combinational N-bit ALU with signed-overflow, zero and operand-equality flags.
module alu
    import alu_types::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  alu_control_t control,
    output logic [N-1:0] result,
    output logic         overflow,
    output logic         zero,
    output logic         equal
);

    localparam int SW = $clog2(N);

    always_comb begin
        result   = '0;
        overflow = 1'b0;
        case (control)
            ADD: begin
                result   = a + b;
                overflow = (a[N-1] == b[N-1]) && (result[N-1] != a[N-1]);
            end
            SUB: begin
                result   = a - b;
                overflow = (a[N-1] != b[N-1]) && (result[N-1] != a[N-1]);
            end
            AND: result = a & b;
            OR:  result = a | b;
            XOR: result = a ^ b;
            SLT: result = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
            SLL: result = a << b[SW-1:0];
            SRL: result = a >> b[SW-1:0];
        endcase
    end

    assign zero  = (result == '0);
    assign equal = (a == b);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, one op in flight.
// Define ALU_ARBITER_STATS_EN to add per-requester saturating grant counters.
module alu_arbiter
    import alu_types::*;
#(
    parameter int N = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ALU_ARB_NUM_REQ-1:0] req_valid,
    output logic [ALU_ARB_NUM_REQ-1:0] req_ready,
    input  logic [N-1:0]               a0,
    input  logic [N-1:0]               b0,
    input  logic [N-1:0]               a1,
    input  logic [N-1:0]               b1,
    input  alu_control_t               control0,
    input  alu_control_t               control1,
    output logic [ALU_ARB_NUM_REQ-1:0] rsp_valid,
    input  logic                       rsp_ready,
    output logic [N-1:0]               rsp_result,
    output logic                       rsp_overflow,
    output logic                       rsp_zero,
    output logic                       rsp_equal
`ifdef ALU_ARBITER_STATS_EN
    ,
    output logic [15:0]                grant_count0,
    output logic [15:0]                grant_count1
`endif
);

    alu_arb_state_t state;
    logic           last_id;
    logic           win_id;
    logic           grant;
    logic           id_q;
    logic [N-1:0]   a_q;
    logic [N-1:0]   b_q;
    alu_control_t   ctrl_q;

    logic [N-1:0]   alu_result;
    logic           alu_overflow;
    logic           alu_zero;
    logic           alu_equal;

    // Under contention the requester not granted last wins; a lone request always wins.
    always_comb begin
        win_id = (req_valid == 2'b11) ? ~last_id : req_valid[1];
    end

    always_comb begin
        req_ready = '0;
        if (!rst && state == IDLE && req_valid != '0)
            req_ready[win_id] = 1'b1;
    end

    assign grant = |(req_valid & req_ready);

    alu #(.N(N)) u_alu (
        .a        (a_q),
        .b        (b_q),
        .control  (ctrl_q),
        .result   (alu_result),
        .overflow (alu_overflow),
        .zero     (alu_zero),
        .equal    (alu_equal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            last_id      <= 1'b1;
            id_q         <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            ctrl_q       <= ADD;
            rsp_valid    <= '0;
            rsp_result   <= '0;
            rsp_overflow <= 1'b0;
            rsp_zero     <= 1'b0;
            rsp_equal    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        a_q     <= win_id ? a1 : a0;
                        b_q     <= win_id ? b1 : b0;
                        ctrl_q  <= win_id ? control1 : control0;
                        id_q    <= win_id;
                        last_id <= win_id;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result   <= alu_result;
                    rsp_overflow <= alu_overflow;
                    rsp_zero     <= alu_zero;
                    rsp_equal    <= alu_equal;
                    rsp_valid    <= id_q ? 2'b10 : 2'b01;
                    state        <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_ARBITER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_count0 <= '0;
            grant_count1 <= '0;
        end else if (grant) begin
            if (win_id) begin
                if (grant_count1 != 16'hFFFF)
                    grant_count1 <= grant_count1 + 16'd1;
            end else begin
                if (grant_count0 != 16'hFFFF)
                    grant_count0 <= grant_count0 + 16'd1;
            end
        end
    end
`endif

endmodule
